// File: rtl/mme_pkg.sv
// Shared definitions for the matrix-multiply engine: register map, states, datapath types.
package mme_pkg;

  localparam logic [31:0] REG_IP_VER     = 32'h0000_0000;
  localparam logic [31:0] REG_MAT_CFG    = 32'h0000_0100;
  localparam logic [31:0] REG_MAT_A_ADDR = 32'h0000_0200;
  localparam logic [31:0] REG_MAT_B_ADDR = 32'h0000_0204;
  localparam logic [31:0] REG_MAT_C_ADDR = 32'h0000_0208;
  localparam logic [31:0] REG_MME_CMD    = 32'h0000_020C;
  localparam logic [31:0] REG_MME_STATUS = 32'h0000_0210;

  localparam logic [31:0] IP_VERSION = 32'h0001_0101;

  localparam logic [7:0] RD_BURST_LEN   = 8'd3;
  localparam logic [7:0] WR_BURST_LEN   = 8'd15;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_A_AR,
    ST_RD_A_R,
    ST_RD_B_AR,
    ST_RD_B_R,
    ST_MAC,
    ST_WR_AW,
    ST_WR_W,
    ST_WR_B,
    ST_DONE
  } mme_state_t;

  // acc[r][c], row-major so that a 4-bit beat counter indexes it directly
  typedef logic [3:0][3:0][31:0] acc_array_t;
  typedef logic [3:0][31:0] vec4_t;

  // Each A column / B row occupies 16 bytes, so step k sits at base + 16k
  function automatic logic [31:0] burst_addr(input logic [31:0] base, input logic [31:0] k);
    return base + (k << 4);
  endfunction

endpackage

// File: rtl/mme_if.sv
// Bus interfaces used by the engine: APB register port and the five AXI channels.
interface APB;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
endinterface

interface AXI_AW_CH;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  modport master (output awaddr, awlen, awsize, awburst, awvalid, input awready);
  modport slave  (input awaddr, awlen, awsize, awburst, awvalid, output awready);
endinterface

interface AXI_W_CH;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  modport master (output wdata, wstrb, wlast, wvalid, input wready);
  modport slave  (input wdata, wstrb, wlast, wvalid, output wready);
endinterface

interface AXI_B_CH;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;

  modport master (input bresp, bvalid, output bready);
  modport slave  (output bresp, bvalid, input bready);
endinterface

interface AXI_AR_CH;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  modport master (output araddr, arlen, arsize, arburst, arvalid, input arready);
  modport slave  (input araddr, arlen, arsize, arburst, arvalid, output arready);
endinterface

interface AXI_R_CH;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (input rdata, rresp, rlast, rvalid, output rready);
  modport slave  (output rdata, rresp, rlast, rvalid, input rready);
endinterface

// File: rtl/mme_apb_regs.sv
// APB register file: configuration registers, command decode and status readback.
module mme_apb_regs
  import mme_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  APB.slave           apb_if,
  input  logic        busy,
  input  logic        done,
  output logic        start,
  output logic [31:0] cfg_k,
  output logic [31:0] a_addr,
  output logic [31:0] b_addr,
  output logic [31:0] c_addr
);

  logic        access;
  logic        wr_en;
  logic [31:0] rd_data;

  assign access = apb_if.psel & apb_if.penable;
  assign wr_en  = access & apb_if.pwrite;

  // A start is only honoured while the engine is idle; busy-time commands vanish
  assign start = wr_en && (apb_if.paddr == REG_MME_CMD) && apb_if.pwdata[0] && !busy;

  // Configuration registers capture writes on the access-phase edge, even while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_k  <= '0;
      a_addr <= '0;
      b_addr <= '0;
      c_addr <= '0;
    end else if (wr_en) begin
      case (apb_if.paddr)
        REG_MAT_CFG:    cfg_k  <= apb_if.pwdata;
        REG_MAT_A_ADDR: a_addr <= apb_if.pwdata;
        REG_MAT_B_ADDR: b_addr <= apb_if.pwdata;
        REG_MAT_C_ADDR: c_addr <= apb_if.pwdata;
        default: ;
      endcase
    end
  end

  // Read decode; CMD and unmapped offsets read as zero
  always_comb begin
    rd_data = '0;
    case (apb_if.paddr)
      REG_IP_VER:     rd_data = IP_VERSION;
      REG_MAT_CFG:    rd_data = cfg_k;
      REG_MAT_A_ADDR: rd_data = a_addr;
      REG_MAT_B_ADDR: rd_data = b_addr;
      REG_MAT_C_ADDR: rd_data = c_addr;
      REG_MME_STATUS: rd_data = {31'd0, done};
      default:        rd_data = '0;
    endcase
  end

  assign apb_if.prdata  = (access && !apb_if.pwrite) ? rd_data : 32'd0;
  assign apb_if.pready  = 1'b1;
  assign apb_if.pslverr = 1'b0;

endmodule

// File: rtl/mme_top.sv
// Matrix-multiply engine top: sequencing FSM, AXI master and the 4x4 MAC array.
module mme_top
  import mme_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  APB.slave         apb_if,
  AXI_AW_CH.master  axi_aw_if,
  AXI_W_CH.master   axi_w_if,
  AXI_B_CH.master   axi_b_if,
  AXI_AR_CH.master  axi_ar_if,
  AXI_R_CH.master   axi_r_if
);

  mme_state_t  state;
  mme_state_t  next_state;

  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] cfg_k;
  logic [31:0] cfg_a_addr;
  logic [31:0] cfg_b_addr;
  logic [31:0] cfg_c_addr;

  logic [31:0] k_total;
  logic [31:0] k_idx;
  logic [31:0] a_base;
  logic [31:0] b_base;
  logic [31:0] c_base;
  vec4_t       a_col;
  vec4_t       b_row;
  logic [1:0]  rd_beat;
  logic [3:0]  wr_beat;
  acc_array_t  acc;

  logic        a_beat;
  logic        b_beat;
  logic        w_beat;
  logic        unused_resp;

  assign busy = (state != ST_IDLE);

  // Response codes carry no meaning for this engine
  assign unused_resp = ^{axi_r_if.rresp, axi_b_if.bresp};

  assign a_beat = (state == ST_RD_A_R) && axi_r_if.rvalid;
  assign b_beat = (state == ST_RD_B_R) && axi_r_if.rvalid;
  assign w_beat = (state == ST_WR_W) && axi_w_if.wready;

  mme_apb_regs u_regs (
    .clk    (clk),
    .rst_n  (rst_n),
    .apb_if (apb_if),
    .busy   (busy),
    .done   (done),
    .start  (start),
    .cfg_k  (cfg_k),
    .a_addr (cfg_a_addr),
    .b_addr (cfg_b_addr),
    .c_addr (cfg_c_addr)
  );

  // State register; reset drops every AXI valid/ready since outputs decode from state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and AXI channel outputs, all zero outside their owning state
  always_comb begin
    next_state         = state;
    axi_ar_if.arvalid  = 1'b0;
    axi_ar_if.araddr   = '0;
    axi_ar_if.arlen    = '0;
    axi_ar_if.arsize   = '0;
    axi_ar_if.arburst  = '0;
    axi_r_if.rready    = 1'b0;
    axi_aw_if.awvalid  = 1'b0;
    axi_aw_if.awaddr   = '0;
    axi_aw_if.awlen    = '0;
    axi_aw_if.awsize   = '0;
    axi_aw_if.awburst  = '0;
    axi_w_if.wvalid    = 1'b0;
    axi_w_if.wdata     = '0;
    axi_w_if.wstrb     = '0;
    axi_w_if.wlast     = 1'b0;
    axi_b_if.bready    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (cfg_k == 32'd0) ? ST_WR_AW : ST_RD_A_AR;
        end
      end
      ST_RD_A_AR: begin
        axi_ar_if.arvalid = 1'b1;
        axi_ar_if.araddr  = burst_addr(a_base, k_idx);
        axi_ar_if.arlen   = RD_BURST_LEN;
        axi_ar_if.arsize  = AXI_SIZE_WORD;
        axi_ar_if.arburst = AXI_BURST_INCR;
        if (axi_ar_if.arready) next_state = ST_RD_A_R;
      end
      ST_RD_A_R: begin
        axi_r_if.rready = 1'b1;
        if (axi_r_if.rvalid && axi_r_if.rlast) next_state = ST_RD_B_AR;
      end
      ST_RD_B_AR: begin
        axi_ar_if.arvalid = 1'b1;
        axi_ar_if.araddr  = burst_addr(b_base, k_idx);
        axi_ar_if.arlen   = RD_BURST_LEN;
        axi_ar_if.arsize  = AXI_SIZE_WORD;
        axi_ar_if.arburst = AXI_BURST_INCR;
        if (axi_ar_if.arready) next_state = ST_RD_B_R;
      end
      ST_RD_B_R: begin
        axi_r_if.rready = 1'b1;
        if (axi_r_if.rvalid && axi_r_if.rlast) next_state = ST_MAC;
      end
      ST_MAC: begin
        next_state = (k_idx + 32'd1 == k_total) ? ST_WR_AW : ST_RD_A_AR;
      end
      ST_WR_AW: begin
        axi_aw_if.awvalid = 1'b1;
        axi_aw_if.awaddr  = c_base;
        axi_aw_if.awlen   = WR_BURST_LEN;
        axi_aw_if.awsize  = AXI_SIZE_WORD;
        axi_aw_if.awburst = AXI_BURST_INCR;
        if (axi_aw_if.awready) next_state = ST_WR_W;
      end
      ST_WR_W: begin
        axi_w_if.wvalid = 1'b1;
        axi_w_if.wdata  = acc[wr_beat[3:2]][wr_beat[1:0]];
        axi_w_if.wstrb  = 4'hF;
        axi_w_if.wlast  = (wr_beat == 4'd15);
        if (axi_w_if.wready && (wr_beat == 4'd15)) next_state = ST_WR_B;
      end
      ST_WR_B: begin
        axi_b_if.bready = 1'b1;
        if (axi_b_if.bvalid) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch the job on start, capture read beats, accumulate, step the write beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      k_total <= '0;
      k_idx   <= '0;
      a_base  <= '0;
      b_base  <= '0;
      c_base  <= '0;
      a_col   <= '0;
      b_row   <= '0;
      rd_beat <= '0;
      wr_beat <= '0;
      acc     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            done    <= 1'b0;
            k_total <= cfg_k;
            k_idx   <= '0;
            a_base  <= cfg_a_addr;
            b_base  <= cfg_b_addr;
            c_base  <= cfg_c_addr;
            rd_beat <= '0;
            wr_beat <= '0;
            acc     <= '0;
          end
        end
        ST_RD_A_R: begin
          if (a_beat) begin
            a_col[rd_beat] <= axi_r_if.rdata;
            rd_beat        <= axi_r_if.rlast ? 2'd0 : rd_beat + 2'd1;
          end
        end
        ST_RD_B_R: begin
          if (b_beat) begin
            b_row[rd_beat] <= axi_r_if.rdata;
            rd_beat        <= axi_r_if.rlast ? 2'd0 : rd_beat + 2'd1;
          end
        end
        ST_MAC: begin
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
              acc[r][c] <= acc[r][c] + a_col[r] * b_row[c];
            end
          end
          k_idx <= k_idx + 32'd1;
        end
        ST_WR_W: begin
          if (w_beat) wr_beat <= wr_beat + 4'd1;
        end
        ST_DONE: begin
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mme_top.sv
// Scoreboard bench for mme_top: APB driver, AXI memory model, expected-value queues.
module tb_mme_top;
  import mme_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  APB       apb_bus ();
  AXI_AW_CH aw_bus ();
  AXI_W_CH  w_bus ();
  AXI_B_CH  b_bus ();
  AXI_AR_CH ar_bus ();
  AXI_R_CH  r_bus ();

  mme_top dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .apb_if    (apb_bus),
    .axi_aw_if (aw_bus),
    .axi_w_if  (w_bus),
    .axi_b_if  (b_bus),
    .axi_ar_if (ar_bus),
    .axi_r_if  (r_bus)
  );

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [0:4095];
  logic [31:0] a_m [4][16];
  logic [31:0] b_m [16][4];

  logic [31:0] w_q [$];
  bit          apb_chk_q [$];
  logic [31:0] apb_exp_q [$];
  string       apb_name_q [$];
  logic [31:0] apb_last = '0;

  logic        r_hs_s = 1'b0;
  logic        w_hs_s = 1'b0;
  logic        b_hs_s = 1'b0;
  logic        w_last_s = 1'b0;
  logic [31:0] w_data_s = '0;
  int          ar_count = 0;
  int          r_count = 0;
  int          aw_count = 0;
  logic [31:0] last_awaddr = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Handshake capture on the active edge, consumed by the negedge processes
  always @(posedge clk) begin
    r_hs_s   <= r_bus.rvalid && r_bus.rready;
    w_hs_s   <= w_bus.wvalid && w_bus.wready;
    b_hs_s   <= b_bus.bvalid && b_bus.bready;
    w_data_s <= w_bus.wdata;
    w_last_s <= w_bus.wlast;
    if (ar_bus.arvalid && ar_bus.arready) ar_count <= ar_count + 1;
    if (r_bus.rvalid && r_bus.rready) r_count <= r_count + 1;
    if (aw_bus.awvalid && aw_bus.awready) aw_count <= aw_count + 1;
  end

  // AXI read slave with random beat gaps; aborts on reset
  logic [31:0] rd_addr;
  int rd_len, rd_idx, rd_wait;
  bit rd_abort;
  initial begin
    ar_bus.arready = 1'b0;
    r_bus.rvalid = 1'b0;
    r_bus.rlast = 1'b0;
    r_bus.rdata = '0;
    r_bus.rresp = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ar_bus.arvalid) begin
        rd_addr = ar_bus.araddr;
        rd_len = int'(ar_bus.arlen);
        ar_bus.arready = 1'b1;
        @(negedge clk);
        ar_bus.arready = 1'b0;
        rd_abort = !rst_n;
        for (int i = 0; i <= rd_len && !rd_abort; i++) begin
          rd_wait = $urandom_range(0, 2);
          for (int j = 0; j < rd_wait; j++) begin
            @(negedge clk);
            if (!rst_n) rd_abort = 1;
          end
          if (!rd_abort) begin
            rd_idx = (int'(rd_addr[13:2]) + i) % 4096;
            r_bus.rdata = mem[rd_idx];
            r_bus.rlast = (i == rd_len);
            r_bus.rvalid = 1'b1;
            do begin
              @(negedge clk);
              if (!rst_n) rd_abort = 1;
            end while (!r_hs_s && !rd_abort);
            r_bus.rvalid = 1'b0;
            r_bus.rlast = 1'b0;
          end
        end
      end
    end
  end

  // AXI write slave with random wready stalls and one B response per burst
  logic [31:0] wr_addr;
  int wr_len, wr_i, wr_idx;
  bit wr_abort;
  initial begin
    aw_bus.awready = 1'b0;
    w_bus.wready = 1'b0;
    b_bus.bvalid = 1'b0;
    b_bus.bresp = '0;
    forever begin
      @(negedge clk);
      if (rst_n && aw_bus.awvalid) begin
        wr_addr = aw_bus.awaddr;
        last_awaddr = aw_bus.awaddr;
        wr_len = int'(aw_bus.awlen);
        aw_bus.awready = 1'b1;
        @(negedge clk);
        aw_bus.awready = 1'b0;
        wr_abort = !rst_n;
        wr_i = 0;
        while (wr_i <= wr_len && !wr_abort) begin
          w_bus.wready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (!rst_n) wr_abort = 1;
          if (w_hs_s) begin
            wr_idx = (int'(wr_addr[13:2]) + wr_i) % 4096;
            mem[wr_idx] = w_data_s;
            wr_i++;
          end
        end
        w_bus.wready = 1'b0;
        if (!wr_abort) begin
          b_bus.bvalid = 1'b1;
          do begin
            @(negedge clk);
            if (!rst_n) wr_abort = 1;
          end while (!b_hs_s && !wr_abort);
          b_bus.bvalid = 1'b0;
        end
      end
    end
  end

  // APB read monitor: pops the expected value when an access phase is presented
  bit mon_chk;
  logic [31:0] mon_exp;
  string mon_name;
  initial forever begin
    @(negedge clk);
    if (apb_bus.psel && apb_bus.penable && !apb_bus.pwrite) begin
      apb_last = apb_bus.prdata;
      if (apb_chk_q.size() == 0) begin
        total++;
        $display("[TB] FAIL apb_unexpected: got 0x%08h required no read", apb_last);
      end else begin
        mon_chk = apb_chk_q.pop_front();
        mon_exp = apb_exp_q.pop_front();
        mon_name = apb_name_q.pop_front();
        if (mon_chk) check_output(mon_name, apb_last, mon_exp);
      end
    end
  end

  // C write-back monitor: every accepted W beat must match the head of the queue
  int wb_tb = 0;
  logic [31:0] w_exp;
  initial forever begin
    @(negedge clk);
    if (w_hs_s) begin
      if (w_q.size() == 0) begin
        total++;
        $display("[TB] FAIL w_unexpected: got 0x%08h required no write", w_data_s);
      end else begin
        w_exp = w_q.pop_front();
        check_output("c_word", w_data_s, w_exp);
      end
      check_output("wlast", {31'd0, w_last_s}, {31'd0, (wb_tb == 15)});
      wb_tb = (wb_tb == 15) ? 0 : wb_tb + 1;
    end
  end

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b1;
    apb_bus.paddr = addr; apb_bus.pwdata = data;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1;
    @(posedge clk); #1;
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input string name, input bit chk,
                          input logic [31:0] exp, output logic [31:0] data);
    apb_chk_q.push_back(chk);
    apb_exp_q.push_back(exp);
    apb_name_q.push_back(name);
    @(posedge clk); #1;
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0; apb_bus.paddr = addr;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1;
    @(posedge clk); #1;
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
    data = apb_last;
  endtask

  task automatic check_reg(input logic [31:0] addr, input string name, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, name, 1'b1, exp, d);
  endtask

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < 4; i++) begin
        a_m[i][kk] = 32'($urandom_range(0, 255));
        mem[4*kk + i] = a_m[i][kk];
        b_m[kk][i] = 32'($urandom_range(0, 255));
        mem[1024 + 4*kk + i] = b_m[kk][i];
      end
    end
  endtask

  // Reference product, row-major, low 32 bits of each dot product
  task automatic push_model(input int k);
    logic [31:0] sum;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sum = '0;
        for (int kk = 0; kk < k; kk++) sum = sum + a_m[r][kk] * b_m[kk][c];
        w_q.push_back(sum);
      end
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] k, input logic [31:0] c_addr);
    apb_write(REG_MAT_CFG, k);
    apb_write(REG_MAT_A_ADDR, 32'h0000_0000);
    apb_write(REG_MAT_B_ADDR, 32'h0000_1000);
    apb_write(REG_MAT_C_ADDR, c_addr);
    apb_write(REG_MME_CMD, 32'h1);
  endtask

  task automatic wait_done(input string name);
    logic [31:0] st;
    int n;
    st = '0;
    n = 0;
    while (st[0] !== 1'b1 && n < 600) begin
      apb_read(REG_MME_STATUS, "poll", 1'b0, '0, st);
      n++;
    end
    check_output({name, "_done"}, st, 32'd1);
    check_output({name, "_wq_drained"}, 32'(w_q.size()), 32'd0);
  endtask

  task automatic check_output_op(input string name, input int k);
    logic [31:0] st;
    apply_stimulus(32'(k), 32'h0000_2000);
    apb_read(REG_MME_STATUS, {name, "_done_cleared"}, 1'b1, 32'd0, st);
    wait_done(name);
  endtask

  int ar0, aw0, r0, n;
  logic [31:0] d;

  initial begin
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
    apb_bus.paddr = '0; apb_bus.pwdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_axi_valids",
                 {27'd0, ar_bus.arvalid, r_bus.rready, aw_bus.awvalid, w_bus.wvalid, b_bus.bready}, 32'd0);
    check_output("rst_araddr", ar_bus.araddr, 32'd0);
    check_output("rst_prdata", apb_bus.prdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    check_reg(REG_IP_VER, "ip_ver", 32'h0001_0101);
    check_reg(REG_MME_STATUS, "status_rst", 32'd0);
    check_reg(REG_MAT_CFG, "cfg_rst", 32'd0);

    apb_write(REG_MAT_CFG, 32'd4);
    apb_write(REG_MAT_A_ADDR, 32'h0);
    apb_write(REG_MAT_B_ADDR, 32'h1000);
    apb_write(REG_MAT_C_ADDR, 32'h2000);
    check_reg(REG_MAT_CFG, "cfg_rb", 32'd4);
    check_reg(REG_MAT_A_ADDR, "a_rb", 32'h0);
    check_reg(REG_MAT_B_ADDR, "b_rb", 32'h1000);
    check_reg(REG_MAT_C_ADDR, "c_rb", 32'h2000);
    check_reg(REG_MME_CMD, "cmd_rd0", 32'd0);
    apb_write(32'h0000_0300, 32'hDEAD_BEEF);
    check_reg(32'h0000_0300, "unmapped", 32'd0);

    fill_random(4);  push_model(4);  check_output_op("k4", 4);
    fill_random(8);  push_model(8);  check_output_op("k8", 8);
    fill_random(12); push_model(12); check_output_op("k12", 12);
    fill_random(16); push_model(16); check_output_op("k16", 16);
    check_reg(REG_MME_STATUS, "done_sticky", 32'd1);

    // -1 x 2 summed four times gives -8 in every cell
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < 4; i++) begin
        mem[4*kk + i] = 32'hFFFF_FFFF;
        mem[1024 + 4*kk + i] = 32'd2;
      end
    end
    for (int i = 0; i < 16; i++) w_q.push_back(32'hFFFF_FFF8);
    check_output_op("neg", 4);

    for (int i = 0; i < 16; i++) w_q.push_back(32'd0);
    check_output_op("k0", 0);

    // Busy-time command and register writes must not disturb the running job
    fill_random(4);
    push_model(4);
    ar0 = ar_count;
    aw0 = aw_count;
    apply_stimulus(32'd4, 32'h0000_2000);
    apb_write(REG_MME_CMD, 32'h1);
    apb_write(REG_MAT_C_ADDR, 32'h3000);
    apb_write(REG_MAT_CFG, 32'd8);
    wait_done("busy");
    repeat (20) @(posedge clk);
    check_output("busy_aw_bursts", 32'(aw_count - aw0), 32'd1);
    check_output("busy_ar_bursts", 32'(ar_count - ar0), 32'd8);
    check_output("busy_awaddr", last_awaddr, 32'h0000_2000);
    check_reg(REG_MAT_CFG, "busy_cfg_rb", 32'd8);

    // Reset in the middle of a read burst
    fill_random(16);
    r0 = r_count;
    apply_stimulus(32'd16, 32'h0000_2000);
    n = 0;
    while (r_count < r0 + 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_output("mid_read_reached", 32'(r_count >= r0 + 2), 32'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_output("abort_axi_valids",
                 {27'd0, ar_bus.arvalid, r_bus.rready, aw_bus.awvalid, w_bus.wvalid, b_bus.bready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ar0 = ar_count;
    aw0 = aw_count;
    repeat (40) @(posedge clk);
    check_output("abort_no_ar", 32'(ar_count - ar0), 32'd0);
    check_output("abort_no_aw", 32'(aw_count - aw0), 32'd0);
    apb_read(REG_MME_STATUS, "abort_status", 1'b1, 32'd0, d);
    check_reg(REG_MAT_CFG, "abort_cfg", 32'd0);

    check_output("final_wq_empty", 32'(w_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mme_top.md
# mme_top

Memory-mapped 4×K by K×4 signed integer matrix-multiply engine. Software configures it over an APB slave port. The block fetches A and B from system memory through an AXI master, accumulates C = A×B in 16 on-chip 32-bit accumulators, writes the 4×4 result back to memory, and reports completion in a status register.

## Interface
- No parameters. AXI data width is 32 bits; address width is 32 bits.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- apb_if  slave modport  APB  register port (paddr/psel/penable/pwrite/pwdata/prdata/pready/pslverr)
- axi_aw_if  master  AXI_AW_CH  write address channel
- axi_w_if  master  AXI_W_CH  write data channel
- axi_b_if  master  AXI_B_CH  write response channel
- axi_ar_if  master  AXI_AR_CH  read address channel
- axi_r_if  master  AXI_R_CH  read data channel

## Operation
- Register map (byte offsets):
  - 0x000 IP_VER: read-only, value 0x0001_0101.
  - 0x100 MAT_CFG: read/write, K (matrix width) in bits[31:0].
  - 0x200 MAT_A_ADDR: read/write.
  - 0x204 MAT_B_ADDR: read/write.
  - 0x208 MAT_C_ADDR: read/write.
  - 0x20C MME_CMD: write-only; writing bit0=1 starts; reads return 0.
  - 0x210 MME_STATUS: bit0 = done.
- Unmapped reads return 0; unmapped writes are ignored.
- All R/W registers reset to 0.
- Memory layout:
  - A is column-major: A[r][k] at A_ADDR + 4·(4k+r).
  - B is row-major: B[k][c] at B_ADDR + 4·(4k+c).
  - C is row-major: C[r][c] at C_ADDR + 4·(4r+c).
- Start (CMD write with bit0=1 while idle):
  - Clear done and all 16 accumulators.
  - Latch K and the three addresses.
- For each k = 0..K-1:
  - Read a 4-beat INCR burst at A_ADDR+16k (column k of A).
  - Read a 4-beat INCR burst at B_ADDR+16k (row k of B).
  - Then acc[r][c] += A[r][k]·B[k][c] for all 16 pairs.
- Arithmetic: signed 32×32 multiply, truncated to 32 bits, wrap-around accumulation modulo 2³². C equals the low 32 bits of the exact sum.
- Write-back: one 16-beat INCR burst (awlen=15, awsize=2) at C_ADDR in row-major order. Wait for the B response, then set done=1.
- K=0 skips all reads and writes 16 zero words.
- CMD writes while busy are ignored.
- done stays 1 until the next start.
- Register writes while busy update the registers but do not affect the running operation.
- BRESP/RRESP errors are ignored.

## Timing
- APB: zero wait states, pready=1, pslverr=0.
  - Writes take effect at the ACCESS-phase clock edge.
  - prdata is valid combinationally during ACCESS.
- State machine:
  - IDLE → RD_A_AR → RD_A_R → RD_B_AR → RD_B_R → MAC
  - MAC → RD_A_AR when k<K-1, else WR_AW
  - WR_AW → WR_W → WR_B → DONE → IDLE
- Each MAC step takes 1 cycle.
- arvalid/awvalid are held until the matching ready; address and len stay stable meanwhile.
- rready=1 only in the R states; beats are captured on rvalid&rready, and rlast ends the burst.
- wvalid is held per beat until wready; wlast is asserted on beat 15.
- bready=1 only in WR_B.
- Reset values: all valid/ready/last outputs 0, addresses/data 0, prdata 0, state IDLE, done 0.
- Reset mid-operation aborts immediately with no further AXI activity.
- Latency is not fixed; it depends on memory response time. Software polls STATUS.

## Structure
- Shared package mme_pkg:
  - register offset constants
  - IP version constant
  - state enum
  - 4×4 accumulator array typedef
- Sub-modules:
  - mme_apb_regs: register file and APB decode, producing start/cfg outputs.
  - mme_top: contains the FSM, AXI master, and MAC array.

## Test plan
- After reset, read 0x000 → 0x0001_0101. Read 0x210 → 0.
- Write 4/0x0/0x1000/0x2000 to MAT_CFG/A/B/C and read back → identical values.
- K=4 with random A,B in [0,255], CMD=1, poll STATUS until 1. The 16 words at 0x2000 must match the reference product's low 32 bits.
- Repeat for K=8, 12 and 16 back-to-back. Done must clear on each start; all C words must match.
- A = all 0xFFFF_FFFF (−1), B = all 2, K=4 → every C word = 0xFFFF_FFF8.
- Write CMD=1 while busy → no second operation starts and the result is unchanged. Assert rst_n low mid-read → AXI valids drop to 0 and STATUS reads 0.
